// File: rtl/approx_mul_err_eval.sv
// Exhaustive operand sweep for an approximate NxN multiplier with a 3-stage error pipeline.
// Define ERR_MAXTRACK_EN to build the max_ed/max_a/max_b tracker; otherwise those outputs are 0.
module approx_mul_err_eval #(
    parameter int N     = 8,
    parameter int SUM_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             hold,
    output logic [N-1:0]     a_out,
    output logic [N-1:0]     b_out,
    input  logic [2*N-1:0]   prod_in,
    output logic             busy,
    output logic             done,
    output logic [2*N:0]     err_cnt,
    output logic [SUM_W-1:0] sum_ed,
    output logic [2*N-1:0]   max_ed,
    output logic [N-1:0]     max_a,
    output logic [N-1:0]     max_b
);
    localparam int PW = 2*N;
    localparam int SE = SUM_W + 1;

    // state | meaning
    // IDLE  | waiting for start        SWEEP | sampling one pair per non-held cycle
    // DRAIN | two cycles to retire     DONE  | statistics final and held
    typedef enum logic [1:0] {S_IDLE, S_SWEEP, S_DRAIN, S_DONE} state_t;

    state_t        state_q, state_d;
    logic          drain_q, drain_d;
    logic [PW-1:0] idx_q, idx_d;
    logic          sample, last, clear;

    assign sample = (state_q == S_SWEEP) && !hold;
    assign last   = sample && (idx_q == {PW{1'b1}});
    assign clear  = start && ((state_q == S_IDLE) || (state_q == S_DONE));
    assign a_out  = idx_q[PW-1:N];
    assign b_out  = idx_q[N-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            drain_q <= 1'b0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            drain_q <= drain_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        drain_d = drain_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) state_d = S_SWEEP;
            end
            S_SWEEP: begin
                if (last) begin
                    state_d = S_DRAIN;
                    drain_d = 1'b1;
                end
            end
            S_DRAIN: begin
                if (drain_q == 1'b0) state_d = S_DONE;
                else                 drain_d = 1'b0;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // The index wraps to zero on the last sample and then stays there.
    always_comb begin
        idx_d = idx_q;
        if (clear)       idx_d = '0;
        else if (sample) idx_d = idx_q + PW'(1);
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state_q)
            S_SWEEP, S_DRAIN: busy = 1'b1;
            S_DONE:           done = 1'b1;
            default: ;
        endcase
    end

    logic          v1_q, v2_q;
    logic [PW-1:0] exact1_q, prod1_q, ed2_q;
    logic [PW-1:0] exact_w, ed_w;
    logic [PW:0]   err_q;
    logic [SUM_W-1:0] sum_q, sum_sat;
    logic [SUM_W:0]   sum_ext;

    assign exact_w = PW'(a_out) * PW'(b_out);
    assign ed_w    = (exact1_q >= prod1_q) ? (exact1_q - prod1_q) : (prod1_q - exact1_q);
    assign sum_ext = {1'b0, sum_q} + SE'(ed2_q);
    assign sum_sat = sum_ext[SUM_W] ? {SUM_W{1'b1}} : sum_ext[SUM_W-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q     <= 1'b0;
            v2_q     <= 1'b0;
            exact1_q <= '0;
            prod1_q  <= '0;
            ed2_q    <= '0;
            err_q    <= '0;
            sum_q    <= '0;
        end else begin
            v1_q <= sample;
            if (sample) begin
                exact1_q <= exact_w;
                prod1_q  <= prod_in;
            end
            v2_q <= v1_q;
            if (v1_q) ed2_q <= ed_w;
            if (clear) begin
                err_q <= '0;
                sum_q <= '0;
            end else if (v2_q) begin
                if (ed2_q != '0) err_q <= err_q + (PW+1)'(1);
                sum_q <= sum_sat;
            end
        end
    end

    assign err_cnt = err_q;
    assign sum_ed  = sum_q;

`ifdef ERR_MAXTRACK_EN
    logic [N-1:0]  a1_q, b1_q, a2_q, b2_q, max_a_q, max_b_q;
    logic [PW-1:0] max_ed_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            a1_q     <= '0;
            b1_q     <= '0;
            a2_q     <= '0;
            b2_q     <= '0;
            max_ed_q <= '0;
            max_a_q  <= '0;
            max_b_q  <= '0;
        end else begin
            if (sample) begin
                a1_q <= a_out;
                b1_q <= b_out;
            end
            if (v1_q) begin
                a2_q <= a1_q;
                b2_q <= b1_q;
            end
            // Strict compare keeps the earliest pair on ties.
            if (clear) begin
                max_ed_q <= '0;
                max_a_q  <= '0;
                max_b_q  <= '0;
            end else if (v2_q && (ed2_q > max_ed_q)) begin
                max_ed_q <= ed2_q;
                max_a_q  <= a2_q;
                max_b_q  <= b2_q;
            end
        end
    end

    assign max_ed = max_ed_q;
    assign max_a  = max_a_q;
    assign max_b  = max_b_q;
`else
    assign max_ed = '0;
    assign max_a  = '0;
    assign max_b  = '0;
`endif

endmodule

// File: tb/tb_approx_mul_err_eval.sv
// Scoreboard bench for approx_mul_err_eval at N=4: a full-width instance and a narrow
// SUM_W instance that exercises sum saturation, both driven by the same stimulus.
module tb_approx_mul_err_eval;
    localparam int N    = 4;
    localparam int W    = 2*N;
    localparam int NP   = 1 << W;
    localparam int SW   = 32;
    localparam int SWS  = 12;
    localparam longint unsigned SAT_S = (64'd1 << SWS) - 1;
    localparam longint unsigned SAT_L = (64'd1 << SW) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1, start = 1'b0, hold = 1'b0;
    int   mode_r = 2;
    logic [W-1:0] tab [NP];

    logic [N-1:0]  a0, b0, a1, b1, ma0, mb0, ma1, mb1;
    logic [W-1:0]  p0, p1, mx0, mx1;
    logic          busy0, done0, busy1, done1;
    logic [W:0]    err0, err1;
    logic [SW-1:0] sum0;
    logic [SWS-1:0] sum1;

    always #5 clk = ~clk;

    // Behavioural multiplier under test.
    function automatic logic [W-1:0] approx(input int m, input int a, input int b);
        case (m)
            0: return W'(a * b);
            1: return W'(a * b + 1);
            2: return '0;
            default: return tab[a * (1 << N) + b];
        endcase
    endfunction

    assign p0 = approx(mode_r, int'(a0), int'(b0));
    assign p1 = approx(mode_r, int'(a1), int'(b1));

    approx_mul_err_eval #(.N(N), .SUM_W(SW)) u_dut (
        .clk(clk), .rst(rst), .start(start), .hold(hold),
        .a_out(a0), .b_out(b0), .prod_in(p0), .busy(busy0), .done(done0),
        .err_cnt(err0), .sum_ed(sum0), .max_ed(mx0), .max_a(ma0), .max_b(mb0));

    approx_mul_err_eval #(.N(N), .SUM_W(SWS)) u_sat (
        .clk(clk), .rst(rst), .start(start), .hold(hold),
        .a_out(a1), .b_out(b1), .prod_in(p1), .busy(busy1), .done(done1),
        .err_cnt(err1), .sum_ed(sum1), .max_ed(mx1), .max_a(ma1), .max_b(mb1));

    typedef struct {
        longint unsigned err, sum, sum_s, mx, ma, mb, cycles;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0, n_fail = 0;
    longint unsigned cyc = 0, start_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input longint unsigned act, input longint unsigned exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Reference statistics straight from the definition: visit every pair in index order.
    function automatic exp_t model(input int m);
        exp_t e;
        longint unsigned ex, p, ed;
        e = '{default: 0};
        for (int a = 0; a < (1 << N); a++) begin
            for (int b = 0; b < (1 << N); b++) begin
                ex = longint'(a * b);
                p  = 64'(approx(m, a, b));
                ed = (ex > p) ? ex - p : p - ex;
                if (ed != 0) e.err++;
                e.sum   = (e.sum + ed > SAT_L) ? SAT_L : e.sum + ed;
                e.sum_s = (e.sum_s + ed > SAT_S) ? SAT_S : e.sum_s + ed;
                if (ed > e.mx) begin
                    e.mx = ed;
                    e.ma = longint'(a);
                    e.mb = longint'(b);
                end
            end
        end
`ifndef ERR_MAXTRACK_EN
        e.mx = 0;
        e.ma = 0;
        e.mb = 0;
`endif
        return e;
    endfunction

    // Monitor: every rising done retires one scoreboard entry.
    initial begin
        logic done_prev;
        exp_t e;
        done_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (done0 && !done_prev) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("done_latency", cyc - start_cyc, e.cycles);
                    chk("err_cnt", 64'(err0), e.err);
                    chk("sum_ed", 64'(sum0), e.sum);
                    chk("max_ed", 64'(mx0), e.mx);
                    chk("max_a", 64'(ma0), e.ma);
                    chk("max_b", 64'(mb0), e.mb);
                    chk("sat_done", 64'(done1), 1);
                    chk("sat_err_cnt", 64'(err1), e.err);
                    chk("sat_sum_ed", 64'(sum1), e.sum_s);
                end
            end
            done_prev = done0;
        end
    end

    task automatic run_sweep(input int m, input int pct, input int burst_at,
                             input int burst_len, input bit extra);
        bit   hp[$];
        int   ones;
        exp_t e;
        ones   = 0;
        mode_r = m;
        for (int k = 0; k < NP; k++) begin
            if (k == burst_at) begin
                repeat (burst_len) begin
                    hp.push_back(1'b1);
                    ones++;
                end
            end
            while (int'($urandom_range(0, 99)) < pct) begin
                hp.push_back(1'b1);
                ones++;
            end
            hp.push_back(1'b0);
        end
        e = model(m);
        e.cycles = longint'(NP + ones + 2);
        exp_q.push_back(e);

        start = 1'b1;
        tick();
        start = 1'b0;
        start_cyc = cyc;
        chk("busy_after_start", 64'(busy0), 1);
        chk("done_clr_on_start", 64'(done0), 0);
        foreach (hp[i]) begin
            hold  = hp[i];
            start = extra && (i == hp.size() / 2);
            tick();
        end
        hold  = extra;
        start = extra;
        tick();
        hold  = 1'b0;
        start = 1'b0;
        for (int i = 0; i < 10 && !done0; i++) tick();
        if (!done0) chk("done_timeout", 64'(done0), 1);
        repeat (3) tick();
        chk("done_held", 64'(done0), 1);
        chk("busy_low_done", 64'(busy0), 0);
    endtask

    initial begin
        for (int i = 0; i < NP; i++) tab[i] = W'(i);
        repeat (3) tick();
        chk("rst_a_out", 64'(a0), 0);
        chk("rst_b_out", 64'(b0), 0);
        chk("rst_busy", 64'(busy0), 0);
        chk("rst_done", 64'(done0), 0);
        chk("rst_err_cnt", 64'(err0), 0);
        chk("rst_sum_ed", 64'(sum0), 0);
        chk("rst_max_ed", 64'(mx0), 0);
        rst = 1'b0;
        tick();

        run_sweep(0, 0, -1, 0, 1'b0);
        run_sweep(1, 0, -1, 0, 1'b0);
        run_sweep(2, 0, -1, 0, 1'b0);
        run_sweep(2, 0, 100, 10, 1'b1);

        for (int i = 0; i < NP; i++)
            tab[i] = ($urandom_range(0, 1) == 1) ? W'((i >> N) * (i % (1 << N))) : W'($urandom);
        run_sweep(3, 20, -1, 0, 1'b1);

        // Reset in the middle of a sweep; the abandoned sweep must never report done.
        mode_r = 2;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (150) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_a_out", 64'(a0), 0);
        chk("midrst_b_out", 64'(b0), 0);
        chk("midrst_busy", 64'(busy0), 0);
        chk("midrst_done", 64'(done0), 0);
        chk("midrst_err_cnt", 64'(err0), 0);
        chk("midrst_sum_ed", 64'(sum0), 0);
        chk("midrst_max_ed", 64'(mx0), 0);
        chk("midrst_max_a", 64'(ma0), 0);
        chk("midrst_max_b", 64'(mb0), 0);
        repeat (5) tick();
        chk("midrst_idle", 64'(busy0), 0);
        run_sweep(2, 0, -1, 0, 1'b0);

        for (int i = 0; i < NP; i++)
            tab[i] = ($urandom_range(0, 3) == 0) ? W'((i >> N) * (i % (1 << N))) : W'($urandom);
        run_sweep(3, 35, 40, 5, 1'b1);

        repeat (5) tick();
        chk("scoreboard_empty", 64'(exp_q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/approx_mul_err_eval.md
# approx_mul_err_eval

Sequential error-evaluation stage for the 8x8 approximate multipliers built from four 4x4 partial-product cells and a combining adder. It sweeps every operand pair, drives the pairs into the multiplier under test, and takes back its 16-bit product. For each pair it computes the exact product and error distance (ED) and accumulates on-chip error statistics: error count, ED sum, and maximum ED with its operands. The multiplier under test is purely combinational and sits between `a_out`/`b_out` and `prod_in`.

## Interface
Parameters:
- `N` — 8 — operand width; product width is 2N.
- `SUM_W` — 32 — ED-sum accumulator width.

Ports:
- `clk` — in — 1 — single clock, rising edge.
- `rst` — in — 1 — reset, synchronous, active-high.
- `start` — in — 1 — begins a sweep; sampled only in IDLE or DONE.
- `hold` — in — 1 — stalls the operand sweep while high.
- `a_out` — out — N — operand A to the multiplier under test.
- `b_out` — out — N — operand B to the multiplier under test.
- `prod_in` — in — 2N — approximate product, a combinational function of `a_out`/`b_out`.
- `busy` — out — 1 — a sweep or pipeline drain is in progress.
- `done` — out — 1 — statistics are final.
- `err_cnt` — out — 2N+1 — count of pairs with ED ≠ 0.
- `sum_ed` — out — SUM_W — sum of ED over all pairs.
- `max_ed` — out — 2N — largest ED seen.
- `max_a` — out — N — operand A of the first pair reaching `max_ed`.
- `max_b` — out — N — operand B of the first pair reaching `max_ed`.

## Operation
- States: IDLE, SWEEP, DRAIN, DONE.
- **IDLE → SWEEP** on `start`.
  - On that edge, clear all statistics and set `a_out = 0`, `b_out = 0`.
- **SWEEP:** each cycle with `hold = 0`, sample the pair.
  - Capture `exact = a_out*b_out` (2N bits) and `prod_in` into stage 1.
  - Advance the index `{a_out, b_out}` by 1; `b_out` is the LSB half.
- **Stage 2:** `ed = |exact − prod_in|`, unsigned 2N bits. It never overflows.
- **Stage 3 (accumulate):**
  - If `ed ≠ 0`, increment `err_cnt`.
  - Add `ed` to `sum_ed`; `sum_ed` saturates at all-ones if SUM_W is too narrow.
  - If `ed > max_ed` (strictly greater), update `max_ed`, `max_a`, `max_b`. Ties keep the earliest pair.
- **SWEEP → DRAIN** on the edge that samples pair (2^N−1, 2^N−1).
  - The index wraps to 0 and `a_out`/`b_out` then hold 0.
- **DRAIN:** lasts 2 cycles, then → DONE.
- **DONE:** statistics are held and `done = 1`.
  - `start` clears statistics and re-enters SWEEP exactly as from IDLE.
- `start` during SWEEP or DRAIN is ignored.
- `hold = 1` in SWEEP: the index is frozen and no sample is taken. A bubble enters the pipeline and in-flight samples still retire. `hold` is ignored outside SWEEP.
- Stage valid bits qualify the accumulation; a bubble never modifies statistics.
- `rst` at any time, including mid-sweep:
  - state = IDLE;
  - all outputs, valid bits and stage registers = 0.

## Timing
- Reset values: `a_out`, `b_out`, `busy`, `done`, `err_cnt`, `sum_ed`, `max_ed`, `max_a`, `max_b` are all 0.
- `start` sampled at edge T0:
  - `busy` = 1 after T0;
  - pairs are sampled at edges T1 … T(2^2N);
  - final accumulation at T(2^2N + 2); at that same edge `busy` → 0 and `done` → 1.
- For N = 8: `done` rises at T65538 with no hold. Each hold cycle in SWEEP adds exactly one cycle.
- Sample-to-statistics latency is 2 edges: a pair sampled at Tk is reflected at Tk+2.
- `done` stays 1 until the next accepted `start` (cleared on that edge) or `rst`.

## Configuration
- `ERR_MAXTRACK_EN` defined:
  - the `max_ed`/`max_a`/`max_b` comparator and registers are built and behave as above.
- Not defined:
  - those three outputs are constant 0 and no comparator logic is generated;
  - `err_cnt`, `sum_ed` and all timing are unchanged.

## Test plan
- **Exact model** (`prod_in = a_out*b_out`), N = 8, pulse `start`:
  - `done` rises 65538 cycles after the start edge;
  - `err_cnt = 0`, `sum_ed = 0`, `max_ed = 0`.
- **Offset model** (`prod_in = a_out*b_out + 1`):
  - `err_cnt = 65536`, `sum_ed = 65536`, `max_ed = 1`;
  - `max_a = 0`, `max_b = 0` (earliest tie kept).
- **Zero model** (`prod_in = 0`):
  - `err_cnt = 65025`, `sum_ed = 1065369600`;
  - `max_ed = 65025`, `max_a = 255`, `max_b = 255`.
- **Hold:** zero model, `hold` high for 10 cycles starting at pair 1000, plus one extra `start` pulse mid-sweep:
  - `done` rises at cycle 65548;
  - statistics identical to the zero-model case;
  - the extra `start` has no effect.
- **Reset mid-sweep:** `rst` at pair 30000:
  - next cycle all outputs are 0 and state is IDLE;
  - a following `start` yields the full zero-model results.
- **Macro off:** zero model built without `ERR_MAXTRACK_EN`:
  - `max_ed`, `max_a`, `max_b` are 0 throughout;
  - `err_cnt` and `sum_ed` match the zero-model case.
